// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame link types, default widths and field helper
// Shared by the frame receiver and the frame transmitter.
//   FRAME_DATA_W  : default frame payload width
//   FRAME_FIELD_W : default field width
//   NUM_FIELDS    : fields per frame
//   rx_state_t    : receiver FSM states
//   get_field()   : extracts field k from a frame word
package frame_pkg;

    localparam int FRAME_DATA_W  = 27;
    localparam int FRAME_FIELD_W = 9;
    localparam int NUM_FIELDS    = FRAME_DATA_W / FRAME_FIELD_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    function automatic logic [FRAME_FIELD_W-1:0] get_field(
        input logic [FRAME_DATA_W-1:0] word,
        input int                      k
    );
        return word[k*FRAME_FIELD_W +: FRAME_FIELD_W];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset value
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous active-low reset, loads RST_VAL into both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/frame_rx.sv
// rtl/frame_rx.sv - serial frame receiver (start, DATA_W bits LSB first, stop)
// Ports:
//   clk_i       : system clock, rising edge
//   rst_i       : asynchronous active-low reset
//   rx_i        : serial line, idle high, asynchronous to clk_i
//   data_o      : last good frame; field k = data_o[k*FIELD_W +: FIELD_W]
//   done_o      : one-cycle pulse, data_o just updated with a good frame
//   frame_err_o : one-cycle pulse, stop bit sampled low
//   busy_o      : high whenever the FSM is not idle
module frame_rx
    import frame_pkg::*;
#(
    parameter int DATA_W       = FRAME_DATA_W,
    parameter int FIELD_W      = FRAME_FIELD_W,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic rx_s;

    rx_state_t         state_q,   state_d;
    logic [TMR_W-1:0]  timer_q,   timer_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    timer_d = '0;
                end
            end

            // Re-check the line at mid start bit so a short low glitch is
            // dropped without disturbing the outputs.
            ST_START: begin
                if (timer_q == TMR_HALF) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        timer_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            // Timer was zeroed at mid start bit, so each wrap lands mid-bit.
            // Bits arrive LSB first and are shifted in from the top.
            ST_DATA: begin
                if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_STOP: begin
                if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            // A held-low line must not be mistaken for a new start bit.
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_o      = data_q;
    assign done_o      = done_q;
    assign frame_err_o = err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_rx.sv
// tb/tb_frame_rx.sv - self-checking bench for frame_rx
module tb_frame_rx;
    import frame_pkg::*;

    localparam int DW  = 27;
    localparam int CPB = 4;
    localparam int FRAME_CYC = (DW + 2) * CPB;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          rx_i  = 1'b1;
    logic [DW-1:0] data_o;
    logic          done_o;
    logic          frame_err_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    int            done_cnt = 0;
    int            err_cnt  = 0;
    time           last_done_t = 0;
    time           prev_done_t = 0;
    logic [DW-1:0] prev_data = '0;

    frame_rx #(
        .DATA_W       (DW),
        .FIELD_W      (9),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .done_o      (done_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (done_o && frame_err_o) begin
                checks++; errors++;
                $display("FAIL pulse_overlap done=%0b err=%0b required not both", done_o, frame_err_o);
            end
            if (done_o) begin
                done_cnt++;
                prev_done_t = last_done_t;
                last_done_t = $time;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done data=%h required no pulse", data_o);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (data_o !== e) begin
                        errors++;
                        $display("FAIL sb_data got=%h required=%h", data_o, e);
                    end
                end
            end else if (data_o !== prev_data) begin
                checks++; errors++;
                $display("FAIL data_stable got=%h required=%h", data_o, prev_data);
            end
            if (frame_err_o) err_cnt++;
        end
        prev_data = data_o;
    end

    task automatic bit_out(input logic b);
        rx_i = b;
        repeat (CPB) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input logic stop_b);
        bit_out(1'b0);
        for (int i = 0; i < DW; i++) bit_out(w[i]);
        bit_out(stop_b);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 4 * FRAME_CYC) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy_o) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d busy=%0b required 0/0", name, exp_q.size(), busy_o);
        end
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        rx_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if (data_o !== '0 || done_o !== 1'b0 || frame_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs data=%h done=%b err=%b busy=%b required 0", data_o, done_o, frame_err_o, busy_o);
        end
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_good_frame();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(27'h0C0401);
        send_frame(27'h0C0401, 1'b1);
        wait_drain("good");
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL good_done_count got=%0d required=1", done_cnt - d0);
        end
        checks++;
        if (err_cnt != e0) begin
            errors++; $display("FAIL good_err_count got=%0d required=0", err_cnt - e0);
        end
        checks++;
        if (get_field(data_o, 2) !== 9'd3 || get_field(data_o, 1) !== 9'd2 || get_field(data_o, 0) !== 9'd1) begin
            errors++;
            $display("FAIL good_fields got=%0d,%0d,%0d required=3,2,1",
                     get_field(data_o, 2), get_field(data_o, 1), get_field(data_o, 0));
        end
    endtask

    task automatic test_bad_stop();
        int d0, e0;
        logic [DW-1:0] held;
        d0 = done_cnt; e0 = err_cnt; held = data_o;
        send_frame(27'h7FFFFFF, 1'b0);
        repeat (9 * CPB) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL badstop_busy_held got=%b required=1", busy_o);
        end
        rx_i = 1'b1;
        repeat (6) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL badstop_busy_release got=%b required=0", busy_o);
        end
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            errors++; $display("FAIL badstop_pulses err=%0d done=%0d required 1/0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (data_o !== held) begin
            errors++; $display("FAIL badstop_data got=%h required=%h", data_o, held);
        end
    endtask

    task automatic test_glitch();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        rx_i = 1'b0;
        repeat (CPB / 4) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (12) @(negedge clk_i);
        checks++;
        if (done_cnt != d0 || err_cnt != e0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch_ignored done=%0d err=%0d busy=%b required 0/0/0", done_cnt - d0, err_cnt - e0, busy_o);
        end
        exp_q.push_back(27'h1);
        send_frame(27'h1, 1'b1);
        wait_drain("glitch_follow");
        checks++;
        if (data_o !== 27'h1 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL glitch_follow data=%h done=%0d required 0000001/1", data_o, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(27'h0C0401);
        exp_q.push_back(27'h3FFFE00);
        send_frame(27'h0C0401, 1'b1);
        send_frame(27'h3FFFE00, 1'b1);
        wait_drain("b2b");
        checks++;
        if (done_cnt - d0 != 2 || err_cnt != e0) begin
            errors++; $display("FAIL b2b_pulses done=%0d err=%0d required 2/0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (last_done_t - prev_done_t != FRAME_CYC * 10) begin
            errors++; $display("FAIL b2b_spacing got=%0t required=%0d", last_done_t - prev_done_t, FRAME_CYC * 10);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0, e0;
        logic [DW-1:0] w;
        w = 27'h0C0401;
        bit_out(1'b0);
        for (int i = 0; i < 13; i++) bit_out(w[i]);
        rx_i = w[13];
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (data_o !== '0 || done_o !== 1'b0 || frame_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs data=%h done=%b err=%b busy=%b required 0", data_o, done_o, frame_err_o, busy_o);
        end
        rx_i = 1'b1;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        repeat (2 * FRAME_CYC) @(negedge clk_i);
        checks++;
        if (done_cnt != d0 || err_cnt != e0 || data_o !== '0) begin
            errors++;
            $display("FAIL midreset_abort done=%0d err=%0d data=%h required 0/0/0", done_cnt - d0, err_cnt - e0, data_o);
        end
        exp_q.push_back(27'h000ABC);
        send_frame(27'h000ABC, 1'b1);
        wait_drain("midreset_next");
        checks++;
        if (data_o !== 27'h000ABC) begin
            errors++; $display("FAIL midreset_next got=%h required=0000abc", data_o);
        end
    endtask

    task automatic test_loopback();
        int d0, e0;
        logic [DW-1:0] w;
        d0 = done_cnt; e0 = err_cnt;
        for (int n = 0; n < 100; n++) begin
            w = DW'($urandom);
            exp_q.push_back(w);
            send_frame(w, 1'b1);
            rx_i = 1'b1;
            repeat ($urandom_range(10, 20)) @(negedge clk_i);
        end
        wait_drain("loopback");
        checks++;
        if (done_cnt - d0 != 100 || err_cnt != e0) begin
            errors++; $display("FAIL loopback_counts done=%0d err=%0d required 100/0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_stop();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_rx.md
# frame_rx

Serial frame receiver: the receiving end of the team's 27-bit start-triggered serial frame link. It recovers a frame of three 9-bit fields from an asynchronous one-wire line and presents the full word with a one-cycle completion pulse. It sits at the far side of the link from the frame transmitter, directly behind the pin. A loopback bench pairs it with that transmitter.

## Interface
- DATA_W, 27: frame payload width in bits.
- FIELD_W, 9: field width; DATA_W is a multiple of FIELD_W (3 fields).
- CLKS_PER_BIT, 4: clk_i cycles per serial bit; legal range ≥ 2.
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
- rx_i  in  1  serial line, idle high, asynchronous to clk_i.
- data_o  out  DATA_W  last good frame; field k = data_o[k*FIELD_W +: FIELD_W].
- done_o  out  1  one-cycle pulse: data_o just updated with a good frame.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- rx_i passes through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
- Frame on the line: start bit (0), then DATA_W data bits LSB first, then stop bit (1).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: rx_s == 0 -> START, clear bit-timer.
- START: at timer == CLKS_PER_BIT/2 - 1 (mid start bit), sample rx_s.
  - Sample 0 -> DATA, reset timer and bit counter.
  - Sample 1 -> glitch: return to IDLE with no pulse and no output change.
- DATA: every CLKS_PER_BIT cycles (mid-bit), shift rx_s into the shift register MSB end, right-shifting.
  - After bit DATA_W-1 -> STOP.
  - Bit counter width is $clog2(DATA_W); it never wraps past DATA_W-1.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - Sample 1: load data_o from the shift register, pulse done_o, go to IDLE.
  - Sample 0: pulse frame_err_o, leave data_o unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err_o.
- A new start bit immediately after a stop bit is accepted; there are no mandatory idle cycles.
- rx_i activity while busy is ignored for start detection.

## Timing
- Reset values: data_o = 0, done_o = 0, frame_err_o = 0, busy_o = 0, state = IDLE, synchronizer = 1. Reset takes effect immediately.
- Reset deasserted mid-frame: the receiver restarts in IDLE. The partial frame is discarded, and no pulse is issued for it.
- Start detect: 2 clk_i cycles after the falling edge of rx_i (synchronizer delay).
- done_o and frame_err_o go high in the cycle after the stop-bit sample and last exactly 1 cycle. They are never high together.
- data_o changes only in the cycle done_o is high, and is stable otherwise.
- Frame duration on the line: (DATA_W+2)*CLKS_PER_BIT cycles. done_o follows the end of the stop bit's midpoint by ≤ 3 cycles.
- busy_o goes high in the cycle after START entry and low in the cycle done_o pulses (or on WAIT_IDLE exit).

## Structure
- Package frame_pkg holds:
  - DATA_W and FIELD_W defaults, and NUM_FIELDS = DATA_W/FIELD_W;
  - the FSM state enum rx_state_t;
  - the helper function that extracts field k.
- The transmitter shares frame_pkg.
- Sub-module sync_2ff (parameterized reset value) contains the synchronizer; frame_rx instantiates it once.
- Everything else (timer, bit counter, shift register, FSM) is flat in frame_rx.

## Test plan
- Good frame: reset, then send fields 3,2,1 (word 27'h0C0401), CLKS_PER_BIT=4.
  - Required: data_o = 27'h0C0401, exactly one done_o pulse, frame_err_o never high.
  - Required: field2 = 3, field1 = 2, field0 = 1.
- Bad stop bit: send 27'h7FFFFFF with the stop bit driven 0, then release the line high after 10 bits.
  - Required: one frame_err_o pulse, data_o holds the previous value.
  - Required: busy_o falls only after the line returns high.
- Start glitch: rx_i low for 1 bit/4 of a bit period, then high.
  - Required: no done_o, no frame_err_o, return to IDLE.
  - Required: a following good frame 27'h1 is received correctly.
- Back-to-back: frames 27'h0C0401 and 27'h3FFFE00 with no idle gap.
  - Required: two done_o pulses (CLKS_PER_BIT*29 cycles apart), data_o taking each value in order.
- Reset mid-frame: assert rst_i low at data bit 13 of 27'h0C0401, release, then send 27'h000ABC.
  - Required: outputs 0 during reset, no pulse for the aborted frame, then data_o = 27'h000ABC.
- Loopback: 100 random 27-bit words sent from the transmitter at random 100–200 ns gaps.
  - Required: every word received intact, in order, with zero frame errors.
